uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

Serial receiver for the AES-128 UART link. It recovers 8N1 frames from the asynchronous `rx_serial_in` pin and emits each received byte as a one-cycle strobe. It sits directly upstream of the message packer: `uart_byte_out` and `RX_DV_out` drive the packer's `uart_byte_in` and `RX_DV_in`. It also flags malformed frames so top-level logic can drop a corrupted 32-byte plaintext/key burst.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 4..4095.
- `clk` input 1: single system clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `rx_serial_in` input 1: asynchronous serial line; idles high.
- `uart_byte_out` output 8: last correctly framed byte, held until the next good frame.
- `RX_DV_out` output 1: one-cycle strobe marking a new valid `uart_byte_out`.
- `RX_frame_err_out` output 1: one-cycle strobe raised when the stop bit is sampled low.

## Operation
- Input synchronizer: a 2-flop chain. Its second stage, `rx_sync`, is the only version of the line the FSM sees.
- Counters:
  - `clk_cnt` is `$clog2(CLKS_PER_BIT)` bits wide.
  - `bit_idx` is 3 bits wide.
  - Define H = (CLKS_PER_BIT-1)/2, using integer division.
- State `s_IDLE`:
  - `clk_cnt` = 0 and `bit_idx` = 0.
  - If `rx_sync` = 0, go to `s_START`.
- State `s_START`: `clk_cnt` increments each cycle. When `clk_cnt` = H:
  - `rx_sync` = 0: go to `s_DATA` and clear `clk_cnt`.
  - `rx_sync` = 1: the low level was a glitch. Go to `s_IDLE`; no output activity.
- State `s_DATA`: `clk_cnt` increments. When `clk_cnt` = CLKS_PER_BIT-1:
  - `shift[bit_idx]` <= `rx_sync` (LSB first), and `clk_cnt` clears.
  - If `bit_idx` = 7, go to `s_STOP`; otherwise increment `bit_idx`.
- State `s_STOP`: `clk_cnt` increments. When `clk_cnt` = CLKS_PER_BIT-1:
  - `rx_sync` = 1: `uart_byte_out` <= shift, `RX_DV_out` <= 1, go to `s_IDLE`.
  - `rx_sync` = 0: `RX_frame_err_out` <= 1, `uart_byte_out` unchanged, go to `s_BREAK`.
- State `s_BREAK`: wait until `rx_sync` = 1, then go to `s_IDLE`. This prevents a held-low break from being decoded as a stream of 0x00 bytes.
- Illegal state encodings go to `s_IDLE`.
- `RX_DV_out` and `RX_frame_err_out` are registered. They are never high in the same cycle, and each is cleared the cycle after it is set.

## Timing
- Reset (synchronous, active-low):
  - Outputs: `uart_byte_out` = 0x00, `RX_DV_out` = 0, `RX_frame_err_out` = 0.
  - Internal: both synchronizer flops = 1, state = `s_IDLE`, counters = 0.
- Reset asserted mid-frame:
  - The frame is abandoned on the next edge with no strobe.
  - After release, the receiver waits for a fresh falling edge. A low line at release is treated as a start candidate, so the `s_START` check applies.
- Latency: let edge k be the first rising edge at which `rx_serial_in` is low. Then `RX_DV_out` (or `RX_frame_err_out`) is high in exactly the cycle following edge k+3+H+9·CLKS_PER_BIT.
- Sample points:
  - Data bit j is sampled at edge k+3+H+(j+1)·CLKS_PER_BIT.
  - The stop bit is sampled at edge k+3+H+9·CLKS_PER_BIT.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. `s_IDLE` is re-entered at the stop-sample edge, so no frame is lost at 0% baud error.
- There is no backpressure. The consumer must accept each strobe; a byte is valid on `uart_byte_out` from the strobe cycle until the next strobe.

## Test plan
Benches use CLKS_PER_BIT = 16 (H = 7).
- Reset, then drive frame 0x53: `RX_DV_out` is high for one cycle at edge k+154 with `uart_byte_out` = 0x53; `RX_frame_err_out` stays 0.
- 32 back-to-back frames 0x00..0x1F with no idle gap: 32 DV strobes exactly 160 cycles apart, bytes in order. Then, feeding the packer, its `MP_dv_out` asserts.
- Low glitch of 5 cycles on an idle line: no DV, no error; the FSM returns to `s_IDLE`. A following valid frame 0xA5 is received correctly.
- Frame 0xC3 with the stop bit driven low and the line then held low for 100 bit times: one `RX_frame_err_out` pulse, no DV, `uart_byte_out` keeps its previous value. After the line returns high, frame 0x7E is received.
- Assert `rst_n` = 0 during data bit 4 of frame 0xFF, release, then send 0x12: no strobe for the aborted frame; 0x12 is delivered, and `uart_byte_out` = 0x00 until then.

Source files
------------

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with byte strobe and frame-error strobe
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial_in,
    output logic [7:0] uart_byte_out,
    output logic       RX_DV_out,
    output logic       RX_frame_err_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        s_IDLE  = 3'd0,
        s_START = 3'd1,
        s_DATA  = 3'd2,
        s_STOP  = 3'd3,
        s_BREAK = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] clk_cnt, cnt_nxt;
    logic [2:0]    bit_idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    byte_nxt;
    logic          dv_nxt, err_nxt;
    logic          rx_meta, rx_sync;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_serial_in;
            rx_sync <= rx_meta;
        end
    end

    // State, counters, shift register and registered strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= s_IDLE;
            clk_cnt          <= '0;
            bit_idx          <= 3'd0;
            shift            <= 8'h00;
            uart_byte_out    <= 8'h00;
            RX_DV_out        <= 1'b0;
            RX_frame_err_out <= 1'b0;
        end else begin
            state            <= state_nxt;
            clk_cnt          <= cnt_nxt;
            bit_idx          <= idx_nxt;
            shift            <= shift_nxt;
            uart_byte_out    <= byte_nxt;
            RX_DV_out        <= dv_nxt;
            RX_frame_err_out <= err_nxt;
        end
    end

    // Next-state logic: mid-bit start validation, data sampling, stop check
    always_comb begin
        state_nxt = state;
        cnt_nxt   = clk_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift;
        byte_nxt  = uart_byte_out;
        dv_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            s_IDLE: begin
                cnt_nxt = '0;
                idx_nxt = 3'd0;
                if (!rx_sync) begin
                    state_nxt = s_START;
                end
            end
            s_START: begin
                if (clk_cnt == HALF) begin
                    cnt_nxt   = '0;
                    // A line that is high again at mid-start was only a glitch
                    state_nxt = rx_sync ? s_IDLE : s_DATA;
                end else begin
                    cnt_nxt = clk_cnt + 1'b1;
                end
            end
            s_DATA: begin
                if (clk_cnt == LAST) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_sync;
                    if (bit_idx == 3'd7) begin
                        state_nxt = s_STOP;
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = clk_cnt + 1'b1;
                end
            end
            s_STOP: begin
                if (clk_cnt == LAST) begin
                    cnt_nxt = '0;
                    if (rx_sync) begin
                        byte_nxt  = shift;
                        dv_nxt    = 1'b1;
                        state_nxt = s_IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = s_BREAK;
                    end
                end else begin
                    cnt_nxt = clk_cnt + 1'b1;
                end
            end
            s_BREAK: begin
                // Hold here while the line stays low so a break is not read as 0x00 bytes
                cnt_nxt = '0;
                idx_nxt = 3'd0;
                if (rx_sync) begin
                    state_nxt = s_IDLE;
                end
            end
            default: begin
                state_nxt = s_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed self-checking bench for uart_rx_byte
module tb_uart_rx_byte;

    localparam int CPB = 16;
    localparam int LAT = 154;
    localparam int FRAME = 160;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] byte_out;
    logic       dv;
    logic       ferr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_k;

    int         dv_cyc[$];
    logic [7:0] dv_byte[$];
    int         err_cyc[$];

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_serial_in    (rx),
        .uart_byte_out   (byte_out),
        .RX_DV_out       (dv),
        .RX_frame_err_out(ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes away from the active edge
    always @(negedge clk) begin
        if (dv) begin
            dv_cyc.push_back(cyc);
            dv_byte.push_back(byte_out);
        end
        if (ferr) err_cyc.push_back(cyc);
        if (dv || ferr) begin
            total++;
            if (dv && ferr) begin
                bad++;
                $display("FAIL strobe_overlap: dv=%0b err=%0b required not both at cycle %0d", dv, ferr, cyc);
            end
        end
    end

    task automatic clear_log();
        dv_cyc.delete();
        dv_byte.delete();
        err_cyc.delete();
    endtask

    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 rx = 1'b0;
        last_k = cyc + 1;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic expect_one_byte(input string name, input logic [7:0] exp_b, input int exp_cyc);
        total++;
        if (dv_cyc.size() !== 1) begin
            bad++;
            $display("FAIL %s_dv_count: got %0d required 1", name, dv_cyc.size());
        end else begin
            total++;
            if (dv_byte[0] !== exp_b) begin
                bad++;
                $display("FAIL %s_byte: got %h required %h", name, dv_byte[0], exp_b);
            end
            total++;
            if (dv_cyc[0] !== exp_cyc) begin
                bad++;
                $display("FAIL %s_dv_cycle: got %0d required %0d", name, dv_cyc[0], exp_cyc);
            end
        end
        total++;
        if (err_cyc.size() !== 0) begin
            bad++;
            $display("FAIL %s_err_count: got %0d required 0", name, err_cyc.size());
        end
    endtask

    task automatic test_reset();
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h required 00", byte_out); end
        total++;
        if (dv !== 1'b0) begin bad++; $display("FAIL reset_dv: got %b required 0", dv); end
        total++;
        if (ferr !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", ferr); end
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_single();
        clear_log();
        send_frame(8'h53, 1'b1);
        repeat (5) @(posedge clk);
        expect_one_byte("single", 8'h53, last_k + LAT);
        @(negedge clk);
        total++;
        if (byte_out !== 8'h53) begin bad++; $display("FAIL single_hold: got %h required 53", byte_out); end
    endtask

    task automatic test_back_to_back();
        int k0;
        clear_log();
        for (int i = 0; i < 32; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 0) k0 = last_k;
        end
        repeat (5) @(posedge clk);
        total++;
        if (dv_cyc.size() !== 32) begin
            bad++;
            $display("FAIL b2b_count: got %0d required 32", dv_cyc.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                total++;
                if (dv_byte[i] !== 8'(i)) begin
                    bad++;
                    $display("FAIL b2b_byte%0d: got %h required %h", i, dv_byte[i], 8'(i));
                end
                total++;
                if (dv_cyc[i] !== k0 + LAT + FRAME * i) begin
                    bad++;
                    $display("FAIL b2b_cycle%0d: got %0d required %0d", i, dv_cyc[i], k0 + LAT + FRAME * i);
                end
            end
        end
        total++;
        if (err_cyc.size() !== 0) begin bad++; $display("FAIL b2b_err: got %0d required 0", err_cyc.size()); end
    endtask

    task automatic test_glitch();
        clear_log();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        total++;
        if (dv_cyc.size() !== 0) begin bad++; $display("FAIL glitch_dv: got %0d required 0", dv_cyc.size()); end
        total++;
        if (err_cyc.size() !== 0) begin bad++; $display("FAIL glitch_err: got %0d required 0", err_cyc.size()); end
        send_frame(8'hA5, 1'b1);
        repeat (5) @(posedge clk);
        expect_one_byte("glitch_next", 8'hA5, last_k + LAT);
    endtask

    task automatic test_frame_err();
        int k_bad;
        clear_log();
        send_frame(8'hC3, 1'b0);
        k_bad = last_k;
        repeat (100 * CPB) @(posedge clk);
        total++;
        if (err_cyc.size() !== 1) begin
            bad++;
            $display("FAIL ferr_count: got %0d required 1", err_cyc.size());
        end else begin
            total++;
            if (err_cyc[0] !== k_bad + LAT) begin
                bad++;
                $display("FAIL ferr_cycle: got %0d required %0d", err_cyc[0], k_bad + LAT);
            end
        end
        total++;
        if (dv_cyc.size() !== 0) begin bad++; $display("FAIL ferr_dv: got %0d required 0", dv_cyc.size()); end
        @(negedge clk);
        total++;
        if (byte_out !== 8'hA5) begin bad++; $display("FAIL ferr_hold: got %h required a5", byte_out); end
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        clear_log();
        send_frame(8'h7E, 1'b1);
        repeat (5) @(posedge clk);
        expect_one_byte("after_break", 8'h7E, last_k + LAT);
    endtask

    task automatic test_reset_mid();
        clear_log();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (byte_out !== 8'h00) begin bad++; $display("FAIL midrst_byte: got %h required 00", byte_out); end
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        total++;
        if (dv_cyc.size() !== 0 || err_cyc.size() !== 0) begin
            bad++;
            $display("FAIL midrst_strobe: dv=%0d err=%0d required 0 and 0", dv_cyc.size(), err_cyc.size());
        end
        @(negedge clk);
        total++;
        if (byte_out !== 8'h00) begin bad++; $display("FAIL midrst_idle_byte: got %h required 00", byte_out); end
        send_frame(8'h12, 1'b1);
        repeat (5) @(posedge clk);
        expect_one_byte("midrst_next", 8'h12, last_k + LAT);
    endtask

    initial begin
        rx = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
